// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO; frames go out back-to-back
// while the FIFO holds data. tx is registered and idles high.
module uart_tx_fifo #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CPB_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CPB_W-1:0] CELL_LAST = CPB_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  state_e           state_q, state_d;
  logic [CPB_W-1:0] cell_q, cell_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             push, pop, nonempty, cell_end;

  assign tx_ready   = !rst && (count_q != FULL);
  assign push       = tx_valid && tx_ready;
  assign nonempty   = (count_q != '0);
  assign cell_end   = (cell_q == CELL_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

  // Pointers wrap for free because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cell_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          cell_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (cell_end) begin
          cell_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end
      DATA: begin
        // shift_q[0] is the bit on the line; shift right to expose the next one.
        if (cell_end) begin
          cell_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end
      STOP: begin
        if (cell_end) begin
          cell_d = '0;
          if (nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-time model checked every cycle, a line receiver,
// and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [4:0] fifo_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(12000000), .BAUD(750000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  // Model: queue of waiting bytes plus an active frame indexed by cycle-in-frame.
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      bit acc;
      acc = tx_valid && (mq.size() != DEPTH);
      if (!m_act) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front(); m_act = 1'b1; m_t = 0;
        end
      end else if (m_t == FRAME - 1) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front(); m_t = 0;
        end else m_act = 1'b0;
      end else m_t++;
      if (acc) mq.push_back(tx_data);
    end
  end

  function automatic logic m_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  always @(negedge clk) begin
    chk("tx", tx, m_tx());
    chk("busy", busy, m_act);
    chk("fifo_count", fifo_count, mq.size());
    chk("tx_ready", tx_ready, (!rst && mq.size() != DEPTH));
  end

  // Line receiver sampling at bit-cell centres.
  logic [7:0] rx_q[$];
  bit         r_on = 1'b0;
  int         r_c = 0;
  logic       r_prev = 1'b1;
  logic [7:0] r_b = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      r_on = 1'b0; r_prev = 1'b1;
    end else begin
      if (!r_on) begin
        if (r_prev && !tx) begin r_on = 1'b1; r_c = 0; end
      end else begin
        r_c++;
        if (r_c % CPB == CPB/2 && r_c / CPB >= 1 && r_c / CPB <= 8) r_b[r_c/CPB-1] = tx;
        if (r_c == 9*CPB + CPB/2) begin rx_q.push_back(r_b); r_on = 1'b0; end
      end
      r_prev = tx;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [7:0] b[$]);
    foreach (b[i]) begin
      tx_valid = 1'b1; tx_data = b[i];
      cyc(1);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int n, output int pk);
    n = 0; pk = fifo_count;
    while ((busy || fifo_count != 0) && n < lim) begin
      cyc(1); n++;
      if (fifo_count > pk) pk = fifo_count;
    end
    if (n >= lim) tmo("wait_idle");
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, rx_q.size(), e.size());
    foreach (e[i]) if (i < rx_q.size()) chk(nm, rx_q[i], e[i]);
  endtask

  initial begin
    logic [7:0] e[$];
    logic [7:0] frm[10];
    int n, pk;

    // Reset state
    cyc(3);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0); chk("rst_ready", tx_ready, 0);
    rst = 1'b0; #1;
    chk("rel_ready", tx_ready, 1);
    cyc(2);

    // Single byte 0x41 into idle block
    rx_q.delete();
    frm = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
    tx_valid = 1'b1; tx_data = 8'h41;
    cyc(1); tx_valid = 1'b0;
    chk("a_cnt1", fifo_count, 1); chk("a_tx_hi", tx, 1); chk("a_busy0", busy, 0);
    cyc(1);
    chk("a_tx_lo", tx, 0); chk("a_busy1", busy, 1); chk("a_cnt0", fifo_count, 0);
    cyc(CPB/2);
    chk("a_cell0", tx, frm[0][0]);
    for (int k = 1; k < 10; k++) begin
      cyc(CPB);
      chk("a_cell", tx, frm[k][0]);
    end
    cyc(CPB/2 - 1);
    chk("a_busy_last", busy, 1);
    cyc(1);
    chk("a_idle_busy", busy, 0); chk("a_idle_tx", tx, 1);
    e = '{8'h41};
    chk_rx("a_rx", e);
    cyc(5);

    // Three consecutive pushes, back-to-back frames
    rx_q.delete();
    e = '{8'h55, 8'hAA, 8'h00};
    push_seq(e);
    wait_idle(5*FRAME, n, pk);
    chk("b_peak", pk, 2);
    chk("b_len", n, 3*FRAME - 1);
    chk_rx("b_rx", e);
    cyc(5);

    // Hold valid 20 cycles, then hold 0x80 against a full FIFO
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      cyc(1);
    end
    chk("c_full", fifo_count, 16); chk("c_ready0", tx_ready, 0);
    tx_data = 8'h80;
    n = 0;
    while (fifo_count != 15 && n < 2*FRAME) begin cyc(1); n++; end
    if (n >= 2*FRAME) tmo("c_pop");
    chk("c_cnt15", fifo_count, 15); chk("c_ready1", tx_ready, 1);
    cyc(1);
    chk("c_cnt16", fifo_count, 16);
    tx_valid = 1'b0;
    wait_idle(20*FRAME, n, pk);
    e.delete();
    for (int i = 0; i < 17; i++) e.push_back(8'(i));
    e.push_back(8'h80);
    chk_rx("c_rx", e);
    cyc(5);

    // Reset mid-frame with bytes queued
    rx_q.delete();
    e = '{8'hF0, 8'h11, 8'h22, 8'h33};
    push_seq(e);
    chk("d_cnt3", fifo_count, 3);
    cyc(3*CPB);
    rst = 1'b1; #1;
    chk("d_tx", tx, 1); chk("d_busy", busy, 0);
    chk("d_cnt", fifo_count, 0); chk("d_ready", tx_ready, 0);
    @(posedge clk); #1; rst = 1'b0; #1;
    cyc(3*FRAME);
    chk("d_quiet_busy", busy, 0); chk("d_quiet_tx", tx, 1);
    rx_q.delete();
    e = '{8'h3C};
    push_seq(e);
    wait_idle(2*FRAME, n, pk);
    chk_rx("d_rx", e);
    cyc(5);

    // Pointer wrap: 40 bytes in bursts of 7
    rx_q.delete();
    e.delete();
    for (int i = 0; i < 40; i++) e.push_back(8'((i*37 + 5) & 255));
    for (int b = 0; b < 40; b += 7) begin
      logic [7:0] burst[$];
      burst.delete();
      for (int j = b; j < b + 7 && j < 40; j++) burst.push_back(e[j]);
      push_seq(burst);
      n = 0;
      while (fifo_count != 0 && n < 9*FRAME) begin cyc(1); n++; end
      if (n >= 9*FRAME) tmo("e_drain");
    end
    wait_idle(2*FRAME, n, pk);
    chk_rx("e_rx", e);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
